// File: rtl/nexus_ctrl_initiator.sv
// nexus_ctrl_initiator: host-side control initiator with credit tracking, watchdog and flush
package nexus_ctrl_pkg;
  typedef logic [31:0] control_request_t;
  typedef logic [31:0] control_response_t;
endpackage

module nexus_ctrl_initiator
  import nexus_ctrl_pkg::*;
#(
  parameter int REQ_DEPTH       = 8,
  parameter int RESP_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 1024
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  control_request_t                   i_host_req_data,
  input  logic                               i_host_req_expect,
  input  logic                               i_host_req_valid,
  output logic                               o_host_req_ready,
  output control_request_t                   o_ctrl_req_data,
  output logic                               o_ctrl_req_valid,
  input  logic                               i_ctrl_req_ready,
  input  control_response_t                  i_ctrl_resp_data,
  input  logic                               i_ctrl_resp_valid,
  output logic                               o_ctrl_resp_ready,
  output control_response_t                  o_host_resp_data,
  output logic                               o_host_resp_valid,
  input  logic                               i_host_resp_ready,
  input  logic                               i_flush,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding,
  output logic                               o_timeout,
  output logic                               o_idle
);
  localparam int QA = $clog2(REQ_DEPTH);
  localparam int PA = $clog2(RESP_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int WW = $clog2(TIMEOUT + 2);
  localparam logic [1:0] RUN = 2'd0, FLUSH_WAIT = 2'd1, FLUSH_CLR = 2'd2;
  logic [1:0] state;
  control_request_t req_mem [REQ_DEPTH];
  logic [REQ_DEPTH-1:0] exp_mem;
  control_response_t resp_mem [RESP_DEPTH];
  logic [QA:0] req_wp, req_rp, req_level;
  logic [PA:0] resp_wp, resp_rp, resp_level;
  logic [OW-1:0] outstanding;
  logic [WW-1:0] wd;
  logic held, timeout_q;
  logic head_exp, credit_ok, stall, issue, req_push, resp_push, resp_pop;
  logic credit_inc, credit_dec, wd_fire;
  assign req_level  = req_wp - req_rp;
  assign resp_level = resp_wp - resp_rp;
  assign head_exp   = exp_mem[req_rp[QA-1:0]];
  // Credit is judged on registered state only, so a freed credit is usable the next cycle
  assign credit_ok  = int'(outstanding) < MAX_OUTSTANDING &&
                      int'(outstanding) + int'(resp_level) < RESP_DEPTH;
  // A presented request (held) stays valid regardless of later credit or state changes
  assign o_ctrl_req_valid  = req_level != '0 && (held || (state == RUN && (!head_exp || credit_ok)));
  assign o_ctrl_req_data   = o_ctrl_req_valid ? req_mem[req_rp[QA-1:0]] : '0;
  assign o_host_req_ready  = req_level != (QA+1)'(REQ_DEPTH) && state == RUN;
  assign o_ctrl_resp_ready = resp_level != (PA+1)'(RESP_DEPTH);
  assign o_host_resp_valid = resp_level != '0;
  assign o_host_resp_data  = o_host_resp_valid ? resp_mem[resp_rp[PA-1:0]] : '0;
  assign o_outstanding     = outstanding;
  assign o_timeout         = timeout_q;
  assign o_idle            = req_level == '0 && resp_level == '0 && outstanding == '0 && state == RUN;
  assign stall      = o_ctrl_req_valid && !i_ctrl_req_ready;
  assign issue      = o_ctrl_req_valid && i_ctrl_req_ready;
  assign req_push   = i_host_req_valid && o_host_req_ready;
  assign resp_push  = i_ctrl_resp_valid && o_ctrl_resp_ready;
  assign resp_pop   = o_host_resp_valid && i_host_resp_ready;
  assign credit_inc = issue && head_exp;
  // A response with nothing outstanding is unsolicited and must not underflow the count
  assign credit_dec = resp_push && (outstanding != '0 || credit_inc);
  assign wd_fire    = TIMEOUT != 0 && int'(wd) == TIMEOUT;
  // FIFO storage, no reset needed since pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (req_push) begin
      req_mem[req_wp[QA-1:0]] <= i_host_req_data;
      exp_mem[req_wp[QA-1:0]] <= i_host_req_expect;
    end
    if (resp_push) resp_mem[resp_wp[PA-1:0]] <= i_ctrl_resp_data;
  end
  // FIFO pointers and handshake-hold flag; FLUSH_CLR drops the whole request queue at once
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_wp  <= '0;
      req_rp  <= '0;
      resp_wp <= '0;
      resp_rp <= '0;
      held    <= 1'b0;
    end else begin
      req_wp  <= req_wp + (QA+1)'(req_push);
      req_rp  <= state == FLUSH_CLR ? req_wp : req_rp + (QA+1)'(issue);
      resp_wp <= resp_wp + (PA+1)'(resp_push);
      resp_rp <= resp_rp + (PA+1)'(resp_pop);
      held    <= stall;
    end
  end
  // Flush sequencing: wait out any stalled request, clear the queue, return to RUN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= RUN;
    else state <= state == RUN ? (i_flush ? (stall ? FLUSH_WAIT : FLUSH_CLR) : RUN) :
                  state == FLUSH_WAIT ? (stall ? FLUSH_WAIT : FLUSH_CLR) : RUN;
  end
  // Credit counter and watchdog; a watchdog expiry writes off all outstanding credit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outstanding <= '0;
      wd          <= '0;
      timeout_q   <= 1'b0;
    end else begin
      outstanding <= wd_fire ? '0 : outstanding + OW'(credit_inc) - OW'(credit_dec);
      wd          <= (wd_fire || resp_push || outstanding == '0 || TIMEOUT == 0) ? '0 : wd + 1'b1;
      timeout_q   <= timeout_q || wd_fire;
    end
  end
endmodule

// File: tb/tb_nexus_ctrl_initiator.sv
// tb_nexus_ctrl_initiator: scoreboard bench for request issue, credits, flush, watchdog and reset
module tb_nexus_ctrl_initiator;
  import nexus_ctrl_pkg::*;
  logic clk = 0, rst = 1;
  control_request_t  i_host_req_data = '0, o_ctrl_req_data;
  control_response_t i_ctrl_resp_data = '0, o_host_resp_data;
  logic i_host_req_expect = 0, i_host_req_valid = 0, o_host_req_ready;
  logic o_ctrl_req_valid, i_ctrl_req_ready = 0;
  logic i_ctrl_resp_valid = 0, o_ctrl_resp_ready;
  logic o_host_resp_valid, i_host_resp_ready = 0;
  logic i_flush = 0, o_timeout, o_idle;
  logic [2:0] o_outstanding;
  int n_chk = 0, n_fail = 0, n_issued = 0, n_delivered = 0, base;
  logic [31:0] exp_req [$];
  logic [31:0] exp_resp [$];
  logic prev_stall = 0;
  logic [31:0] prev_data = '0;

  nexus_ctrl_initiator #(.REQ_DEPTH(8), .RESP_DEPTH(8), .MAX_OUTSTANDING(4), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_host_req_data(i_host_req_data), .i_host_req_expect(i_host_req_expect),
    .i_host_req_valid(i_host_req_valid), .o_host_req_ready(o_host_req_ready),
    .o_ctrl_req_data(o_ctrl_req_data), .o_ctrl_req_valid(o_ctrl_req_valid),
    .i_ctrl_req_ready(i_ctrl_req_ready),
    .i_ctrl_resp_data(i_ctrl_resp_data), .i_ctrl_resp_valid(i_ctrl_resp_valid),
    .o_ctrl_resp_ready(o_ctrl_resp_ready),
    .o_host_resp_data(o_host_resp_data), .o_host_resp_valid(o_host_resp_valid),
    .i_host_resp_ready(i_host_resp_ready),
    .i_flush(i_flush), .o_outstanding(o_outstanding), .o_timeout(o_timeout), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [31:0] d, input logic e);
    bit done = 0;
    i_host_req_data = d;
    i_host_req_expect = e;
    i_host_req_valid = 1;
    exp_req.push_back(d);
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = o_host_req_ready;
      @(posedge clk);
      #1;
    end
    check("req_accept", 64'(done), 64'd1);
    i_host_req_valid = 0;
  endtask

  task automatic push_resp(input logic [31:0] d);
    bit done = 0;
    i_ctrl_resp_data = d;
    i_ctrl_resp_valid = 1;
    exp_resp.push_back(d);
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = o_ctrl_resp_ready;
      @(posedge clk);
      #1;
    end
    check("resp_accept", 64'(done), 64'd1);
    i_ctrl_resp_valid = 0;
  endtask

  // Mid-cycle monitor: scores every handshake that will complete at the next edge
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) check("req_hold", {31'd0, o_ctrl_req_valid, o_ctrl_req_data}, {32'd1, prev_data});
      if (o_ctrl_req_valid && i_ctrl_req_ready) begin
        n_issued++;
        if (exp_req.size() == 0) check("req_queue", 64'(exp_req.size()), 64'd1);
        else check("req_data", o_ctrl_req_data, exp_req.pop_front());
      end
      if (o_host_resp_valid && i_host_resp_ready) begin
        n_delivered++;
        if (exp_resp.size() == 0) check("resp_queue", 64'(exp_resp.size()), 64'd1);
        else check("resp_data", o_host_resp_data, exp_resp.pop_front());
      end
      prev_stall = o_ctrl_req_valid && !i_ctrl_req_ready;
      prev_data = o_ctrl_req_data;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, o_ctrl_req_valid, 0);
    check({tag, "_resp_valid"}, o_host_resp_valid, 0);
    check({tag, "_outstanding"}, o_outstanding, 0);
    check({tag, "_timeout"}, o_timeout, 0);
    check({tag, "_host_ready"}, o_host_req_ready, 1);
    check({tag, "_resp_ready"}, o_ctrl_resp_ready, 1);
    check({tag, "_idle"}, o_idle, 1);
    check({tag, "_data"}, {o_ctrl_req_data, o_host_resp_data}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 0;
    tick();
    // Three expect=1 requests then three responses
    i_ctrl_req_ready = 1;
    i_host_resp_ready = 1;
    base = n_issued;
    for (int i = 0; i < 3; i++) push_req(32'h1000 + i, 1);
    tick(2);
    check("t1_issued", n_issued - base, 3);
    check("t1_out3", o_outstanding, 3);
    base = n_delivered;
    for (int i = 0; i < 3; i++) push_resp(32'hA000 + i);
    tick(3);
    check("t1_delivered", n_delivered - base, 3);
    check("t1_out0", o_outstanding, 0);
    // Credit limit: six requests, only four issue
    base = n_issued;
    for (int i = 0; i < 6; i++) push_req(32'h2000 + i, 1);
    tick(3);
    check("t2_issued4", n_issued - base, 4);
    check("t2_out4", o_outstanding, 4);
    check("t2_blocked", o_ctrl_req_valid, 0);
    push_resp(32'hB000);
    check("t2_fifth_valid", o_ctrl_req_valid, 1);
    tick();
    check("t2_issued5", n_issued - base, 5);
    for (int i = 1; i < 6; i++) push_resp(32'hB000 + i);
    tick(3);
    check("t2_issued6", n_issued - base, 6);
    check("t2_out0", o_outstanding, 0);
    // Stall with flush mid-stall
    i_ctrl_req_ready = 0;
    base = n_issued;
    for (int i = 0; i < 4; i++) push_req(32'h3000 + i, 0);
    for (int k = 0; k < 5; k++) begin
      i_flush = (k == 1);
      check("t3_stall_valid", {o_ctrl_req_valid, o_ctrl_req_data}, {1'b1, 32'h3000});
      if (k == 3) check("t3_wait_ready", o_host_req_ready, 0);
      tick();
    end
    i_flush = 0;
    i_ctrl_req_ready = 1;
    tick();
    check("t3_clr_ready", o_host_req_ready, 0);
    tick(2);
    exp_req.delete();
    check("t3_issued1", n_issued - base, 1);
    check("t3_idle", o_idle, 1);
    check("t3_no_valid", o_ctrl_req_valid, 0);
    // Watchdog
    push_req(32'h4000, 1);
    tick();
    check("t4_out1", o_outstanding, 1);
    tick(16);
    check("t4_not_yet", o_timeout, 0);
    tick();
    check("t4_timeout", o_timeout, 1);
    check("t4_out0", o_outstanding, 0);
    tick(5);
    check("t4_sticky", o_timeout, 1);
    base = n_issued;
    push_req(32'h4001, 0);
    tick(2);
    check("t4_issue_after", n_issued - base, 1);
    // Unsolicited response, then simultaneous issue and response at count 2
    base = n_delivered;
    push_resp(32'hC000);
    tick();
    check("t5_unsol_out", o_outstanding, 0);
    push_req(32'h5000, 1);
    push_req(32'h5001, 1);
    tick(2);
    check("t5_out2", o_outstanding, 2);
    i_ctrl_req_ready = 0;
    push_req(32'h5002, 1);
    check("t5_presented", o_ctrl_req_valid, 1);
    i_ctrl_req_ready = 1;
    i_ctrl_resp_valid = 1;
    i_ctrl_resp_data = 32'hC001;
    exp_resp.push_back(32'hC001);
    check("t5_resp_ready", o_ctrl_resp_ready, 1);
    tick();
    i_ctrl_resp_valid = 0;
    check("t5_same_cycle", o_outstanding, 2);
    push_resp(32'hC002);
    push_resp(32'hC003);
    tick(3);
    check("t5_delivered", n_delivered - base, 4);
    check("t5_out_final", o_outstanding, 0);
    check("t5_req_q_empty", 64'(exp_req.size()), 0);
    check("t5_resp_q_empty", 64'(exp_resp.size()), 0);
    // Asynchronous reset with both FIFOs partly full
    i_ctrl_req_ready = 0;
    i_host_resp_ready = 0;
    for (int i = 0; i < 3; i++) push_req(32'h6000 + i, 0);
    push_resp(32'hD000);
    push_resp(32'hD001);
    check("t6_pre_resp_valid", o_host_resp_valid, 1);
    #3 rst = 1;
    exp_req.delete();
    exp_resp.delete();
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    i_host_resp_ready = 1;
    base = n_delivered;
    tick(5);
    check("t6_no_delivery", n_delivered - base, 0);
    check("t6_resp_valid", o_host_resp_valid, 0);
    check("t6_idle", o_idle, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
